// File: rtl/vedic_mult_pipe_if.sv
// Handshake bundle for the pipelined Vedic multiplier.
//   in_valid/in_ready : operand-side handshake (a, b, op_signed qualified by in_valid)
//   out_valid/out_ready: product-side handshake (c qualified by out_valid)
//   busy               : some pipeline stage holds a live transaction
// The master modport is the side that supplies operands and consumes products.
// The slave modport is the multiplier itself.
interface vedic_mult_pipe_if #(
    parameter int WIDTH = 16
);
    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH-1:0]       a;
    logic [WIDTH-1:0]       b;
    logic                   op_signed;
    logic                   out_valid;
    logic                   out_ready;
    logic [2*WIDTH-1:0]     c;
    logic                   busy;

    modport master (
        output in_valid, a, b, op_signed, out_ready,
        input  in_ready, out_valid, c, busy
    );

    modport slave (
        input  in_valid, a, b, op_signed, out_ready,
        output in_ready, out_valid, c, busy
    );
endinterface

// File: rtl/vedic_mult_pipe.sv
// Pipelined Urdhva-Tiryagbhyam (Vedic) multiplier, WIDTH x WIDTH -> 2*WIDTH.
// Three register stages: operand magnitudes, four half-width partial products,
// then recombination and sign restore. One product per cycle when not stalled.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset, clears every stage
//   bus    : vedic_mult_pipe_if.slave (in_valid/in_ready, a, b, op_signed,
//            out_valid/out_ready, c, busy)

// Recursive Vedic array: splits each operand in half until the 2x2 urdhva
// cell is reached, then recombines the four sub-products with shifted adds.
module vedic_core #(
    parameter int N = 4
) (
    input  logic [N-1:0]   x,
    input  logic [N-1:0]   y,
    output logic [2*N-1:0] p
);
    if (N == 2) begin : g_cell
        // Vertical / crosswise columns of a 2x2 multiply; the only carry is
        // the one from the crosswise column into the top vertical term.
        logic cross_carry;
        always_comb begin
            p[0]        = x[0] & y[0];
            p[1]        = (x[1] & y[0]) ^ (x[0] & y[1]);
            cross_carry = (x[1] & y[0]) & (x[0] & y[1]);
            p[2]        = (x[1] & y[1]) ^ cross_carry;
            p[3]        = (x[1] & y[1]) & cross_carry;
        end
    end else begin : g_split
        localparam int H = N / 2;
        logic [N-1:0] ll, lh, hl, hh;
        logic [N:0]   mid;

        vedic_core #(.N(H)) u_ll (.x(x[H-1:0]), .y(y[H-1:0]), .p(ll));
        vedic_core #(.N(H)) u_lh (.x(x[H-1:0]), .y(y[N-1:H]), .p(lh));
        vedic_core #(.N(H)) u_hl (.x(x[N-1:H]), .y(y[H-1:0]), .p(hl));
        vedic_core #(.N(H)) u_hh (.x(x[N-1:H]), .y(y[N-1:H]), .p(hh));

        always_comb begin
            mid = {1'b0, lh} + {1'b0, hl};
            p   = {hh, {N{1'b0}}}
                + {{(H-1){1'b0}}, mid, {H{1'b0}}}
                + {{N{1'b0}}, ll};
        end
    end
endmodule

module vedic_mult_pipe #(
    parameter int WIDTH = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    vedic_mult_pipe_if.slave bus
);
    localparam int H = WIDTH / 2;

    logic                 stall;

    logic                 v1_q, v1_d;
    logic                 neg1_q, neg1_d;
    logic [WIDTH-1:0]     ma_q, ma_d;
    logic [WIDTH-1:0]     mb_q, mb_d;

    logic                 v2_q, v2_d;
    logic                 neg2_q, neg2_d;
    logic [WIDTH-1:0]     ll_q, ll_d;
    logic [WIDTH-1:0]     lh_q, lh_d;
    logic [WIDTH-1:0]     hl_q, hl_d;
    logic [WIDTH-1:0]     hh_q, hh_d;

    logic                 out_valid_q, out_valid_d;
    logic [2*WIDTH-1:0]   c_q, c_d;

    logic [WIDTH-1:0]     mag_a, mag_b;
    logic [WIDTH-1:0]     ll_w, lh_w, hl_w, hh_w;
    logic [WIDTH:0]       mid_w;
    logic [2*WIDTH-1:0]   p_w;

    // A stalled output freezes the whole pipe, so the input side is only
    // ready when the product register is free to move.
    assign stall        = out_valid_q & ~bus.out_ready;
    assign bus.in_ready = ~stall;
    assign bus.out_valid = out_valid_q;
    assign bus.c        = c_q;
    assign bus.busy     = v1_q | v2_q | out_valid_q;

    // Half-width partial products of the stored magnitudes.
    vedic_core #(.N(H)) u_ll (.x(ma_q[H-1:0]),     .y(mb_q[H-1:0]),     .p(ll_w));
    vedic_core #(.N(H)) u_lh (.x(ma_q[H-1:0]),     .y(mb_q[WIDTH-1:H]), .p(lh_w));
    vedic_core #(.N(H)) u_hl (.x(ma_q[WIDTH-1:H]), .y(mb_q[H-1:0]),     .p(hl_w));
    vedic_core #(.N(H)) u_hh (.x(ma_q[WIDTH-1:H]), .y(mb_q[WIDTH-1:H]), .p(hh_w));

    // Next-state for all three stages. Bubbles travel with the data; the most
    // negative operand negates to itself, which read as unsigned is exactly
    // its magnitude, so no special case is needed.
    always_comb begin
        v1_d        = v1_q;
        neg1_d      = neg1_q;
        ma_d        = ma_q;
        mb_d        = mb_q;
        v2_d        = v2_q;
        neg2_d      = neg2_q;
        ll_d        = ll_q;
        lh_d        = lh_q;
        hl_d        = hl_q;
        hh_d        = hh_q;
        out_valid_d = out_valid_q;
        c_d         = c_q;

        mag_a = (bus.op_signed & bus.a[WIDTH-1]) ? -bus.a : bus.a;
        mag_b = (bus.op_signed & bus.b[WIDTH-1]) ? -bus.b : bus.b;
        mid_w = {1'b0, lh_q} + {1'b0, hl_q};
        p_w   = {hh_q, {WIDTH{1'b0}}}
              + {{(H-1){1'b0}}, mid_w, {H{1'b0}}}
              + {{WIDTH{1'b0}}, ll_q};

        if (!stall) begin
            v1_d        = bus.in_valid;
            neg1_d      = bus.op_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            ma_d        = mag_a;
            mb_d        = mag_b;
            v2_d        = v1_q;
            neg2_d      = neg1_q;
            ll_d        = ll_w;
            lh_d        = lh_w;
            hl_d        = hl_w;
            hh_d        = hh_w;
            out_valid_d = v2_q;
            c_d         = neg2_q ? -p_w : p_w;
        end
    end

    // Stage registers; reset discards anything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q        <= 1'b0;
            neg1_q      <= 1'b0;
            ma_q        <= '0;
            mb_q        <= '0;
            v2_q        <= 1'b0;
            neg2_q      <= 1'b0;
            ll_q        <= '0;
            lh_q        <= '0;
            hl_q        <= '0;
            hh_q        <= '0;
            out_valid_q <= 1'b0;
            c_q         <= '0;
        end else begin
            v1_q        <= v1_d;
            neg1_q      <= neg1_d;
            ma_q        <= ma_d;
            mb_q        <= mb_d;
            v2_q        <= v2_d;
            neg2_q      <= neg2_d;
            ll_q        <= ll_d;
            lh_q        <= lh_d;
            hl_q        <= hl_d;
            hh_q        <= hh_d;
            out_valid_q <= out_valid_d;
            c_q         <= c_d;
        end
    end
endmodule
